// File: rtl/if_fetch_unit_if.sv
// Decode/IF and instruction-memory signals of the fetch stage, bundled for the fetch unit.
// master = fetch unit, slave = surrounding pipeline/memory.
interface if_fetch_unit_if;
  logic        PC_IFWrite;
  logic        J;
  logic        JR;
  logic        Z;
  logic [31:0] JumpAddr;
  logic [31:0] JrAddr;
  logic [31:0] BranchAddr;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRdata;
  logic [31:0] Instruction_id;
  logic [31:0] NextPC_id;
  logic        Valid_id;

  modport master (
    input  PC_IFWrite, J, JR, Z, JumpAddr, JrAddr, BranchAddr, IMemReady, IMemRdata,
    output IMemReq, IMemAddr, Instruction_id, NextPC_id, Valid_id
  );

  modport slave (
    output PC_IFWrite, J, JR, Z, JumpAddr, JrAddr, BranchAddr, IMemReady, IMemRdata,
    input  IMemReq, IMemAddr, Instruction_id, NextPC_id, Valid_id
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns PC and IF/ID, fetches over a req/ready handshake with a
// one-entry hold buffer for decode stalls and discard of in-flight fetches on redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  if_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_e;

  state_e      state_q;
  logic [31:0] req_addr_q;
  logic [31:0] tgt_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc4_q;
  logic [31:0] instr_q;
  logic [31:0] npc_q;
  logic        valid_q;

  logic        adv;
  logic        redir;
  logic        ready;
  logic [31:0] target;
  logic [31:0] req_pc4;

  assign adv     = bus.PC_IFWrite;
  assign redir   = adv & (bus.J | bus.JR | bus.Z);
  assign ready   = bus.IMemReady;
  assign req_pc4 = req_addr_q + 32'd4;

  always_comb begin
    target = bus.BranchAddr;
    if (bus.JR)     target = bus.JrAddr;
    else if (bus.J) target = bus.JumpAddr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      req_addr_q  <= RESET_PC;
      tgt_q       <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= RESET_PC + 32'd4;
      instr_q     <= NOP_INSTR;
      npc_q       <= RESET_PC + 32'd4;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redir) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            if (ready) begin
              req_addr_q <= target;
            end else begin
              tgt_q   <= target;
              state_q <= DISCARD;
            end
          end else if (ready) begin
            if (adv) begin
              instr_q    <= bus.IMemRdata;
              npc_q      <= req_pc4;
              valid_q    <= 1'b1;
              req_addr_q <= req_pc4;
            end else begin
              buf_instr_q <= bus.IMemRdata;
              buf_pc4_q   <= req_pc4;
              state_q     <= HOLD;
            end
          end else if (adv) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        DISCARD: begin
          // The old request's data is never kept; once it retires, go to the latest target.
          if (adv) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
          if (ready) begin
            req_addr_q <= redir ? target : tgt_q;
            state_q    <= FETCH;
          end else if (redir) begin
            tgt_q <= target;
          end
        end
        HOLD: begin
          if (redir) begin
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            req_addr_q <= target;
            state_q    <= FETCH;
          end else if (adv) begin
            instr_q    <= buf_instr_q;
            npc_q      <= buf_pc4_q;
            valid_q    <= 1'b1;
            req_addr_q <= buf_pc4_q;
            state_q    <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.IMemReq        = (state_q != HOLD) & ~reset;
  assign bus.IMemAddr       = req_addr_q;
  assign bus.Instruction_id = instr_q;
  assign bus.NextPC_id      = npc_q;
  assign bus.Valid_id       = valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against a fetch-stream model.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit_if f();
  if_fetch_unit_if w();

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0001;
  endfunction

  assign f.IMemRdata = mem_fn(f.IMemAddr);
  assign w.IMemRdata = mem_fn(w.IMemAddr);

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(f.master));
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
    .clk(clk), .reset(reset), .bus(w.master));

  // Fetch-stream model: where the stream is, whether it is stalled with a parked
  // instruction, and whether the outstanding request is stale.
  logic [31:0] m_addr, m_tgt, m_pk_instr, m_pk_pc4, m_instr, m_npc;
  logic        m_parked, m_stale, m_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f.PC_IFWrite = 1'b1; f.J = 1'b0; f.JR = 1'b0; f.Z = 1'b0;
    f.JumpAddr = '0; f.JrAddr = '0; f.BranchAddr = '0; f.IMemReady = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic model_step(input logic adv, input logic rdy);
    logic redir, done;
    logic [31:0] target;
    redir  = adv && (f.J || f.JR || f.Z);
    target = f.JR ? f.JrAddr : (f.J ? f.JumpAddr : f.BranchAddr);
    done   = !m_parked && rdy;
    if (adv) begin
      if (redir)                  begin m_instr = 32'h0; m_valid = 1'b0; end
      else if (m_parked)          begin m_instr = m_pk_instr; m_npc = m_pk_pc4; m_valid = 1'b1; end
      else if (done && !m_stale)  begin m_instr = mem_fn(m_addr); m_npc = m_addr + 32'd4; m_valid = 1'b1; end
      else                        begin m_instr = 32'h0; m_valid = 1'b0; end
    end
    if (redir) begin
      if (!m_parked && !done) begin m_stale = 1'b1; m_tgt = target; end
      else begin m_addr = target; m_stale = 1'b0; end
      m_parked = 1'b0;
    end else if (m_parked) begin
      if (adv) begin m_parked = 1'b0; m_addr = m_pk_pc4; end
    end else if (done) begin
      if (m_stale) begin m_addr = m_tgt; m_stale = 1'b0; end
      else if (adv) m_addr = m_addr + 32'd4;
      else begin m_parked = 1'b1; m_pk_instr = mem_fn(m_addr); m_pk_pc4 = m_addr + 32'd4; end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (f.IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", f.IMemReq); end
    checks++; if (f.Instruction_id !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", f.Instruction_id); end
    checks++; if (f.NextPC_id !== 32'h4) begin errors++; $display("FAIL reset_npc got %h exp 4", f.NextPC_id); end
    checks++; if (f.Valid_id !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", f.Valid_id); end
    reset = 1'b0;
    #1;
    checks++; if (f.IMemReq !== 1'b1 || f.IMemAddr !== 32'h0) begin errors++; $display("FAIL first_req got %0b/%h exp 1/0", f.IMemReq, f.IMemAddr); end
  endtask

  task automatic test_zero_wait_stream();
    for (int i = 0; i < 8; i++) begin
      checks++; if (f.IMemAddr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, f.IMemAddr, 32'(4 * i)); end
      tick();
      checks++;
      if (f.Instruction_id !== mem_fn(32'(4 * i)) || f.NextPC_id !== 32'(4 * i + 4) || f.Valid_id !== 1'b1) begin
        errors++; $display("FAIL stream_ifid[%0d] got %h/%h/%0b exp %h/%h/1", i, f.Instruction_id, f.NextPC_id, f.Valid_id, mem_fn(32'(4 * i)), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_load_use_stall();
    do_reset();
    repeat (4) tick();
    f.PC_IFWrite = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (f.IMemReq !== 1'b0 || f.Instruction_id !== mem_fn(32'hC) || f.NextPC_id !== 32'h10 || f.Valid_id !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got req=%0b %h/%h/%0b exp req=0 %h/10/1", k, f.IMemReq, f.Instruction_id, f.NextPC_id, f.Valid_id, mem_fn(32'hC));
      end
    end
    f.PC_IFWrite = 1'b1;
    tick();
    checks++;
    if (f.Instruction_id !== mem_fn(32'h10) || f.NextPC_id !== 32'h14 || f.Valid_id !== 1'b1 || f.IMemAddr !== 32'h14 || f.IMemReq !== 1'b1) begin
      errors++; $display("FAIL stall_release got %h/%h/%0b addr=%h req=%0b", f.Instruction_id, f.NextPC_id, f.Valid_id, f.IMemAddr, f.IMemReq);
    end
    tick();
    checks++; if (f.Instruction_id !== mem_fn(32'h14)) begin errors++; $display("FAIL stall_next got %h exp %h", f.Instruction_id, mem_fn(32'h14)); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    repeat (8) tick();
    f.IMemReady = 1'b0; f.Z = 1'b1; f.BranchAddr = 32'h100;
    tick();
    f.Z = 1'b0;
    checks++;
    if (f.Valid_id !== 1'b0 || f.Instruction_id !== 32'h0 || f.NextPC_id !== 32'h20 || f.IMemAddr !== 32'h20 || f.IMemReq !== 1'b1) begin
      errors++; $display("FAIL redir_bubble got %h/%h/%0b addr=%h req=%0b", f.Instruction_id, f.NextPC_id, f.Valid_id, f.IMemAddr, f.IMemReq);
    end
    tick();
    checks++; if (f.IMemAddr !== 32'h20 || f.Valid_id !== 1'b0) begin errors++; $display("FAIL redir_wait got addr=%h v=%0b exp 20/0", f.IMemAddr, f.Valid_id); end
    f.IMemReady = 1'b1;
    tick();
    checks++; if (f.IMemAddr !== 32'h100 || f.Valid_id !== 1'b0) begin errors++; $display("FAIL redir_drop got addr=%h v=%0b exp 100/0", f.IMemAddr, f.Valid_id); end
    tick();
    checks++;
    if (f.Instruction_id !== mem_fn(32'h100) || f.NextPC_id !== 32'h104 || f.Valid_id !== 1'b1) begin
      errors++; $display("FAIL redir_target got %h/%h/%0b exp %h/104/1", f.Instruction_id, f.NextPC_id, f.Valid_id, mem_fn(32'h100));
    end
  endtask

  task automatic test_jump_priority();
    do_reset();
    repeat (2) tick();
    f.J = 1'b1; f.JR = 1'b1; f.JumpAddr = 32'h400; f.JrAddr = 32'h800;
    tick();
    checks++; if (f.IMemAddr !== 32'h800 || f.Valid_id !== 1'b0) begin errors++; $display("FAIL jr_priority got addr=%h v=%0b exp 800/0", f.IMemAddr, f.Valid_id); end
    f.J = 1'b0; f.JR = 1'b0;
    tick();
    checks++; if (f.Instruction_id !== mem_fn(32'h800)) begin errors++; $display("FAIL jr_fetch got %h exp %h", f.Instruction_id, mem_fn(32'h800)); end
    f.J = 1'b1; f.JR = 1'b1; f.PC_IFWrite = 1'b0;
    tick();
    f.J = 1'b0; f.JR = 1'b0; f.PC_IFWrite = 1'b1;
    checks++; if (f.Instruction_id !== mem_fn(32'h800) || f.IMemReq !== 1'b0) begin errors++; $display("FAIL redir_ignored_hold got %h req=%0b", f.Instruction_id, f.IMemReq); end
    tick();
    checks++;
    if (f.Instruction_id !== mem_fn(32'h804) || f.NextPC_id !== 32'h808 || f.IMemAddr !== 32'h808) begin
      errors++; $display("FAIL redir_ignored_seq got %h/%h addr=%h exp %h/808/808", f.Instruction_id, f.NextPC_id, f.IMemAddr, mem_fn(32'h804));
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] npc_exp;
    do_reset();
    npc_exp = 32'h4;
    for (int k = 0; k < 3; k++) begin
      f.IMemReady = 1'b0;
      for (int b = 0; b < 3; b++) begin
        tick();
        checks++;
        if (f.Valid_id !== 1'b0 || f.Instruction_id !== 32'h0 || f.NextPC_id !== npc_exp) begin
          errors++; $display("FAIL wait_bubble[%0d.%0d] got %h/%h/%0b exp 0/%h/0", k, b, f.Instruction_id, f.NextPC_id, f.Valid_id, npc_exp);
        end
      end
      f.IMemReady = 1'b1;
      tick();
      npc_exp = 32'(4 * k + 4);
      checks++;
      if (f.Valid_id !== 1'b1 || f.Instruction_id !== mem_fn(32'(4 * k)) || f.NextPC_id !== npc_exp) begin
        errors++; $display("FAIL wait_valid[%0d] got %h/%h/%0b exp %h/%h/1", k, f.Instruction_id, f.NextPC_id, f.Valid_id, mem_fn(32'(4 * k)), npc_exp);
      end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    checks++; if (w.NextPC_id !== 32'h0 || w.IMemReq !== 1'b0) begin errors++; $display("FAIL wrap_reset got npc=%h req=%0b exp 0/0", w.NextPC_id, w.IMemReq); end
    reset = 1'b0;
    #1;
    checks++; if (w.IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %h exp fffffffc", w.IMemAddr); end
    tick();
    checks++;
    if (w.NextPC_id !== 32'h0 || w.IMemAddr !== 32'h0 || w.Instruction_id !== mem_fn(32'hFFFF_FFFC) || w.Valid_id !== 1'b1) begin
      errors++; $display("FAIL wrap_next got npc=%h addr=%h instr=%h v=%0b", w.NextPC_id, w.IMemAddr, w.Instruction_id, w.Valid_id);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    repeat (2) tick();
    f.IMemReady = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (f.IMemReq !== 1'b0 || f.Valid_id !== 1'b0 || f.Instruction_id !== 32'h0 || f.NextPC_id !== 32'h4) begin
      errors++; $display("FAIL midreset got req=%0b %h/%h/%0b", f.IMemReq, f.Instruction_id, f.NextPC_id, f.Valid_id);
    end
    reset = 1'b0;
    f.IMemReady = 1'b1;
    #1;
    checks++; if (f.IMemReq !== 1'b1 || f.IMemAddr !== 32'h0) begin errors++; $display("FAIL midreset_restart got %0b/%h exp 1/0", f.IMemReq, f.IMemAddr); end
  endtask

  task automatic test_random();
    logic adv, rdy;
    do_reset();
    m_addr = 32'h0; m_tgt = 32'h0; m_parked = 1'b0; m_stale = 1'b0;
    m_instr = 32'h0; m_npc = 32'h4; m_valid = 1'b0; m_pk_instr = '0; m_pk_pc4 = '0;
    for (int c = 0; c < 3000; c++) begin
      adv = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 6);
      f.PC_IFWrite = adv; f.IMemReady = rdy;
      f.J  = ($urandom_range(0, 19) == 0);
      f.JR = ($urandom_range(0, 19) == 0);
      f.Z  = ($urandom_range(0, 9) == 0);
      f.JumpAddr   = 32'($urandom_range(0, 1023)) << 2;
      f.JrAddr     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 1023)) << 2;
      f.BranchAddr = 32'($urandom_range(0, 1023)) << 2;
      #1;
      checks++; if (f.IMemReq !== !m_parked) begin errors++; $display("FAIL rnd_req[%0d] got %0b exp %0b", c, f.IMemReq, !m_parked); end
      if (!m_parked) begin
        checks++; if (f.IMemAddr !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", c, f.IMemAddr, m_addr); end
      end
      model_step(adv, rdy);
      tick();
      checks++;
      if (f.Instruction_id !== m_instr || f.NextPC_id !== m_npc || f.Valid_id !== m_valid) begin
        errors++; $display("FAIL rnd_ifid[%0d] got %h/%h/%0b exp %h/%h/%0b", c, f.Instruction_id, f.NextPC_id, f.Valid_id, m_instr, m_npc, m_valid);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    w.PC_IFWrite = 1'b1; w.J = 1'b0; w.JR = 1'b0; w.Z = 1'b0;
    w.JumpAddr = '0; w.JrAddr = '0; w.BranchAddr = '0; w.IMemReady = 1'b1;
    #1;
    test_reset();
    test_zero_wait_stream();
    test_load_use_stall();
    test_redirect_pending();
    test_jump_priority();
    test_wait_states();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline and the producer side of the IF/ID interface.
- Owns the PC and the IF/ID pipeline register, and drives Instruction_id/NextPC_id into the decode stage.
- Consumes decode's redirect (J, JR, Z with the three target addresses) and its PC_IFWrite stall.
- Fetches from a variable-latency instruction memory over a req/ready handshake, with a one-entry hold buffer and discard of in-flight fetches on redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted on flush/empty

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
PC_IFWrite  in  1  1 = decode accepts new IF/ID contents; 0 = hold IF/ID
J  in  1  jump redirect from decode
JR  in  1  jump-register redirect from decode
Z  in  1  taken-branch redirect from decode
JumpAddr  in  32  target for J
JrAddr  in  32  target for JR
BranchAddr  in  32  target for Z
IMemReq  out  1  fetch request
IMemAddr  out  32  fetch address, word aligned
IMemReady  in  1  memory completes the request this cycle (may be same cycle as IMemReq)
IMemRdata  in  32  instruction, valid when IMemReq&IMemReady
Instruction_id  out  32  IF/ID instruction
NextPC_id  out  32  IF/ID fetch address + 4
Valid_id  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset values:
  - Instruction_id=NOP_INSTR, NextPC_id=RESET_PC+4, Valid_id=0.
  - State=FETCH, req_addr=RESET_PC.
  - IMemReq=0 during a reset cycle; first request is the cycle after reset deasserts, with IMemAddr=RESET_PC.
  - Reset asserted mid-transaction abandons it; memory must tolerate a dropped request.
- Handshake:
  - IMemReq=1 in FETCH and DISCARD, 0 in HOLD.
  - IMemAddr=req_addr is registered and stable until IMemReady.
  - A transaction completes on any cycle with IMemReq&IMemReady.
  - A new request may issue the cycle after completion, giving peak throughput of 1 instruction/cycle with zero-wait memory.
- Definitions: adv=PC_IFWrite; redir=adv&(J|JR|Z).
  - Target priority: JR>J>Z (JrAddr, JumpAddr, BranchAddr).
  - Redirect is ignored when adv=0, because decode operands are invalid during a load-use stall.
- Whenever adv=0: Instruction_id, NextPC_id and Valid_id hold.
- FETCH state:
  - redir&ready: IF/ID<=bubble; req_addr<=target; stay FETCH.
  - redir&!ready: IF/ID<=bubble; tgt<=target; ->DISCARD.
  - !redir&ready&adv: IF/ID<={IMemRdata, req_addr+4, valid 1}; req_addr<=req_addr+4.
  - !redir&ready&!adv: buf<={IMemRdata, req_addr+4}; ->HOLD.
  - !ready&adv: IF/ID<=bubble (NOP, Valid 0; NextPC_id holds).
- DISCARD state (old request still outstanding, its data is dropped):
  - redir: tgt<=new target (latest wins); IF/ID<=bubble.
  - ready&!redir: req_addr<=tgt; ->FETCH; IF/ID<=bubble if adv.
  - !ready&!redir: wait; IF/ID<=bubble if adv.
  - Data returned in DISCARD is never written to IF/ID or buf.
- HOLD state:
  - redir: drop buf; IF/ID<=bubble; req_addr<=target; ->FETCH.
  - adv&!redir: IF/ID<=buf (valid 1); req_addr<=buf.pc4; ->FETCH.
  - !adv: hold.
- Bubble means Instruction_id=NOP_INSTR and Valid_id=0.
- Arithmetic: all +4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Targets are used verbatim, with no alignment check.
- Latency: the instruction appears in IF/ID on the edge where its transaction completes with adv=1, or the first adv=1 edge after it was buffered.

Test Plan:
- Zero-wait stream: IMemReady=1, PC_IFWrite=1, RESET_PC=0 -> IMemAddr 0,4,8,... each cycle; Instruction_id follows one cycle later; NextPC_id=4,8,12; Valid_id=1 from 2nd cycle after reset.
- Load-use stall: PC_IFWrite=0 for 2 cycles while fetching addr 0x10 completes -> IF/ID holds; HOLD with IMemReq=0; on release Instruction_id=mem[0x10], NextPC_id=0x14, next IMemAddr=0x14; no instruction lost or duplicated.
- Redirect over pending fetch: IMemReady=0 at addr 0x20, Z=1 with BranchAddr=0x100 -> Valid_id=0; IMemAddr stays 0x20 until ready; that data is dropped; next request at 0x100.
- Simultaneous J and JR with JumpAddr=0x400, JrAddr=0x800, PC_IFWrite=1 -> next fetch 0x800. The same redirect with PC_IFWrite=0 is ignored, and the fetch continues at sequential addresses.
- Wait states: IMemReady low 3 cycles per fetch -> 3 bubbles (Valid_id=0, NOP) between valid instructions; NextPC_id correct.
- Wrap and reset: RESET_PC=0xFFFF_FFFC -> NextPC_id=0, next IMemAddr=0. Asserting reset during a pending request -> the next cycle has IMemReq=0 and outputs at reset values.
